// File: rtl/fft_pingpong_ram.sv
// Dual-port, dual-bank (ping-pong) sample RAM for the FFT datapath, with swap handshake and clear FSM.
// Optional: define FFT_RAM_BITREV_EN to bit-reverse the port B address for in-place FFT reordering.
module fft_pingpong_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_vld,
    input  logic              b_en,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_vld,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              clr_req,
    output logic              busy,
    output logic              bank_sel
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;
    logic              bank_d;
    logic              ack_d;
    logic              clr_we;

    logic              idle;
    logic              a_we;
    logic              a_re;
    logic              b_we;
    logic              b_re;
    logic              same_addr;
    logic [ADDR_W-1:0] b_addr_eff;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;

    logic [DATA_W-1:0] mem [2][DEPTH];

`ifdef FFT_RAM_BITREV_EN
    always_comb begin
        b_addr_eff = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            b_addr_eff[i] = b_addr[ADDR_W-1-i];
        end
    end
`else
    assign b_addr_eff = b_addr;
`endif

    // Clear wins over swap when both are requested in IDLE.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        bank_d    = bank_sel;
        ack_d     = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (swap_req) begin
                    bank_d = ~bank_sel;
                    ack_d  = 1'b1;
                end
            end
            CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle      = (state_q == IDLE);
    assign a_we      = idle & a_en & a_wr;
    assign a_re      = idle & a_en & ~a_wr;
    assign b_we      = idle & b_en & b_wr;
    assign b_re      = idle & b_en & ~b_wr;
    assign same_addr = (a_addr == b_addr_eff);
    assign busy      = ~idle;

    // Same-address collisions: A's write beats B's, and a reader sees the concurrent write.
    always_comb begin
        a_rdata = mem[bank_sel][a_addr];
        b_rdata = mem[bank_sel][b_addr_eff];
        if (a_we) begin
            a_rdata = a_din;
        end else if (b_we && same_addr) begin
            a_rdata = b_din;
        end
        if (a_we && same_addr) begin
            b_rdata = a_din;
        end else if (b_we) begin
            b_rdata = b_din;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[bank_sel][clr_cnt_q] <= '0;
        end
        if (b_we && !(a_we && same_addr)) begin
            mem[bank_sel][b_addr_eff] <= b_din;
        end
        if (a_we) begin
            mem[bank_sel][a_addr] <= a_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            bank_sel  <= 1'b0;
            swap_ack  <= 1'b0;
            a_dout    <= '0;
            b_dout    <= '0;
            a_vld     <= 1'b0;
            b_vld     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            bank_sel  <= bank_d;
            swap_ack  <= ack_d;
            a_vld     <= a_we | a_re;
            b_vld     <= b_we | b_re;
            if (a_we || a_re) begin
                a_dout <= a_rdata;
            end
            if (b_we || b_re) begin
                b_dout <= b_rdata;
            end
        end
    end

endmodule
